// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//
// Contents:
//   state_t        FSM encoding (IDLE, BUSY, DONE)
//   BITS_PER_STEP  multiplier bits retired per BUSY cycle (1, or 2 when
//                  SEQ_MULT_RADIX4_EN is defined)
//   mult_latency() BUSY cycles for a given operand width (MULT_LATENCY)
//   prod_width()   product width for a given operand width (2*WIDTH)
//
// Build option: SEQ_MULT_RADIX4_EN selects the two-bits-per-cycle datapath.

package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef SEQ_MULT_RADIX4_EN
    localparam int BITS_PER_STEP = 2;
`else
    localparam int BITS_PER_STEP = 1;
`endif

    function automatic int mult_latency(input int width);
        return width / BITS_PER_STEP;
    endfunction

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier feeding the Barrett reducer.
// One partial product per cycle (two with SEQ_MULT_RADIX4_EN), valid/ready
// handshake on both sides, product held until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high (unless reset)
// BUSY  | accumulating partial products, MULT_LATENCY cycles
// DONE  | product valid and held until out_ready
//
// Parameters:
//   WIDTH      operand width, must be >= 2 and even
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   x, y valid
//   in_ready   operands accepted this cycle when in_valid is also high
//   x, y       unsigned operands (WIDTH bits)
//   out_valid  product valid and held
//   out_ready  consumer accepts product
//   product    x*y, 2*WIDTH bits
//   busy       high in BUSY or DONE
//
// Build option: SEQ_MULT_RADIX4_EN (radix-4 recoding, WIDTH/2 BUSY cycles).

module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PROD_W       = prod_width(WIDTH);
    localparam int MULT_LATENCY = mult_latency(WIDTH);
    localparam int CNT_W        = $clog2(WIDTH + 1);

    state_t state, state_next;

    logic [PROD_W-1:0] a_sh;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] pp;
    logic [PROD_W-1:0] acc_next;
    logic [WIDTH-1:0]  b_sh;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              last_step;
`ifdef SEQ_MULT_RADIX4_EN
    logic [PROD_W-1:0] a3_sh;
`endif

    assign accept    = in_valid && in_ready;
    assign last_step = (state == BUSY) && (cnt == CNT_W'(MULT_LATENCY - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)    state_next = BUSY;
            BUSY: if (last_step) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE) && !reset;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Partial-product select
    always_comb begin
        pp = '0;
`ifdef SEQ_MULT_RADIX4_EN
        unique case (b_sh[1:0])
            2'b00: pp = '0;
            2'b01: pp = a_sh;
            2'b10: pp = {a_sh[PROD_W-2:0], 1'b0};
            2'b11: pp = a3_sh;
            default: pp = '0;
        endcase
`else
        if (b_sh[0]) pp = a_sh;
`endif
    end

    // a_sh < 2^(2*WIDTH - step shift) while bits of b remain, so this never overflows.
    assign acc_next = acc + pp;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
`ifdef SEQ_MULT_RADIX4_EN
            a3_sh   <= '0;
`endif
        end else if (accept) begin
            a_sh  <= {{WIDTH{1'b0}}, x};
            b_sh  <= y;
            acc   <= '0;
            cnt   <= '0;
`ifdef SEQ_MULT_RADIX4_EN
            // 3*x needs at most WIDTH+2 bits, well inside the product width.
            a3_sh <= {{WIDTH{1'b0}}, x} + {{(WIDTH-1){1'b0}}, x, 1'b0};
`endif
        end else if (state == BUSY) begin
            acc   <= acc_next;
            a_sh  <= a_sh << BITS_PER_STEP;
            b_sh  <= b_sh >> BITS_PER_STEP;
            cnt   <= cnt + CNT_W'(1);
`ifdef SEQ_MULT_RADIX4_EN
            a3_sh <= a3_sh << BITS_PER_STEP;
`endif
            if (last_step) product <= acc_next;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=8.
// Expected products and latencies are hand-computed constants.

module tb_seq_multiplier;

    localparam int W = 8;
`ifdef SEQ_MULT_RADIX4_EN
    localparam int EXP_LAT = W / 2 + 1;
`else
    localparam int EXP_LAT = W + 1;
`endif
    localparam int EXP_SPACING = EXP_LAT + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Launches one operation and waits (bounded) for out_valid. Returns the
    // cycle index (accept = 0) at which out_valid was seen, or -1 on timeout.
    // With hold set, in_valid stays high and x/y keep changing while busy.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] ya,
                          input bit hold, output int lat, output logic [2*W-1:0] p);
        @(negedge clk);
        x = xa;
        y = ya;
        in_valid = 1'b1;
        lat = -1;
        @(negedge clk);
        in_valid = hold;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            if (hold) begin
                x = W'($urandom);
                y = W'($urandom);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        p = product;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        y = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got=%h exp=0000", product); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_max_operands();
        int lat;
        logic [2*W-1:0] p;
        out_ready = 1'b1;
        run_op(8'd255, 8'd255, 1'b0, lat, p);
        n_checks++;
        if (p !== 16'hFE01) begin n_fail++; $display("FAIL max_product got=%h exp=fe01", p); end
        n_checks++;
        if (lat != EXP_LAT) begin n_fail++; $display("FAIL max_latency got=%0d exp=%0d", lat, EXP_LAT); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL done_busy got=%b exp=1", busy); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse got=%b exp=0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_values();
        int lat;
        logic [2*W-1:0] p;
        out_ready = 1'b1;
        run_op(8'd13, 8'd11, 1'b0, lat, p);
        n_checks++;
        if (p !== 16'd143) begin n_fail++; $display("FAIL prod_13x11 got=%0d exp=143", p); end
        n_checks++;
        if (lat != EXP_LAT) begin n_fail++; $display("FAIL lat_13x11 got=%0d exp=%0d", lat, EXP_LAT); end
        @(negedge clk);
        run_op(8'd0, 8'd200, 1'b0, lat, p);
        n_checks++;
        if (p !== 16'd0) begin n_fail++; $display("FAIL prod_0x200 got=%0d exp=0", p); end
        n_checks++;
        if (lat != EXP_LAT) begin n_fail++; $display("FAIL lat_0x200 got=%0d exp=%0d", lat, EXP_LAT); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [2*W-1:0] p;
        out_ready = 1'b0;
        run_op(8'd7, 8'd9, 1'b0, lat, p);
        n_checks++;
        if (p !== 16'd63) begin n_fail++; $display("FAIL bp_product got=%0d exp=63", p); end
        n_checks++;
        if (lat != EXP_LAT) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", lat, EXP_LAT); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || product !== 16'd63 || in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_midop();
        int lat;
        logic [2*W-1:0] p;
        out_ready = 1'b1;
        @(negedge clk);
        x = 8'd100;
        y = 8'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (product !== 16'd0) begin n_fail++; $display("FAIL midrst_product got=%0d exp=0", product); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        // reset and in_valid together: nothing accepted
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        x = 8'd5;
        y = 8'd5;
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_vs_valid_busy got=%b exp=0", busy); end
        run_op(8'd2, 8'd3, 1'b0, lat, p);
        n_checks++;
        if (p !== 16'd6) begin n_fail++; $display("FAIL post_rst_product got=%0d exp=6", p); end
        n_checks++;
        if (lat != EXP_LAT) begin n_fail++; $display("FAIL post_rst_latency got=%0d exp=%0d", lat, EXP_LAT); end
        @(negedge clk);
    endtask

    task automatic test_ignored_input();
        int lat;
        logic [2*W-1:0] p;
        out_ready = 1'b1;
        run_op(8'd200, 8'd100, 1'b1, lat, p);
        n_checks++;
        if (p !== 16'd20000) begin n_fail++; $display("FAIL ignored_product got=%0d exp=20000", p); end
        n_checks++;
        if (lat != EXP_LAT) begin n_fail++; $display("FAIL ignored_latency got=%0d exp=%0d", lat, EXP_LAT); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   xs [3];
        logic [W-1:0]   ys [3];
        logic [2*W-1:0] exp_p [3];
        logic [2*W-1:0] got_p [3];
        int acc_cyc [3];
        int n_acc;
        int n_out;
        bit acc_now;
        xs = '{8'd1, 8'd2, 8'd255};
        ys = '{8'd1, 8'd3, 8'd2};
        exp_p = '{16'd1, 16'd6, 16'd510};
        got_p = '{16'd0, 16'd0, 16'd0};
        acc_cyc = '{0, 0, 0};
        n_acc = 0;
        n_out = 0;
        out_ready = 1'b1;
        @(negedge clk);
        x = xs[0];
        y = ys[0];
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            acc_now = in_valid && in_ready;
            if (acc_now && n_acc < 3) acc_cyc[n_acc] = cyc;
            if (out_valid) begin
                if (n_out < 3) got_p[n_out] = product;
                n_out++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                n_acc++;
                if (n_acc < 3) begin
                    x = xs[n_acc];
                    y = ys[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (n_out >= 3 && n_acc >= 3) break;
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_acc != 3) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=3", n_acc); end
        n_checks++;
        if (n_out != 3) begin n_fail++; $display("FAIL b2b_outputs got=%0d exp=3", n_out); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got_p[i] !== exp_p[i]) begin
                n_fail++;
                $display("FAIL b2b_product_%0d got=%0d exp=%0d", i, got_p[i], exp_p[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != EXP_SPACING) begin
                n_fail++;
                $display("FAIL b2b_spacing_%0d got=%0d exp=%0d", i, acc_cyc[i] - acc_cyc[i-1], EXP_SPACING);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max_operands();
        test_values();
        test_backpressure();
        test_reset_midop();
        test_ignored_input();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
